// File: rtl/i2c_master.sv
// Single-master I2C register read/write engine: START, addr+RW, reg addr, one data byte, STOP.
// Each bit slot is four QDIV-cycle quarters; scl/sda are registered from next-state decode.
module i2c_master #(
  parameter int QDIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] mem_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl,
  inout  wire        sda
);

  localparam int CW = $clog2(QDIV);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, MADDR, MADDR_ACK,
    WDATA, WDATA_ACK, RDATA, RNACK, STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] qcnt;
  logic [1:0]    phase, phase_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          ack_err_n;
  logic [7:0]    rdata_n;
  logic          rw_q;
  logic [6:0]    sa_q;
  logic [7:0]    ma_q, wd_q;
  logic          sda_low, sda_low_n, scl_n;
  logic          tick, sda_in;

  // Pin levels as a function of slot state: {scl, pull sda low}
  function automatic logic [1:0] pins(state_t s, logic [1:0] ph, logic b);
    case (s)
      IDLE:                 pins = 2'b10;
      START:                pins = {1'b1, ph[1]};
      ADDR, MADDR, WDATA:   pins = {ph[1], ~b};
      STOP: begin
        case (ph)
          2'd0:    pins = 2'b01;
          2'd1:    pins = 2'b11;
          default: pins = 2'b10;
        endcase
      end
      default:              pins = {ph[1], 1'b0};
    endcase
  endfunction

  assign sda    = sda_low ? 1'b0 : 1'bz;
  assign sda_in = sda;
  assign busy   = (state != IDLE);
  assign tick   = busy && (qcnt == CW'(QDIV - 1));

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bitcnt_n  = bitcnt;
    shreg_n   = shreg;
    ack_err_n = ack_err;
    rdata_n   = rdata;
    done      = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_n   = START;
        phase_n   = 2'd0;
        ack_err_n = 1'b0;
      end
    end else if (tick) begin
      phase_n = phase + 2'd1;
      if (phase == 2'd2) begin
        if ((state == ADDR_ACK || state == MADDR_ACK || state == WDATA_ACK) && sda_in)
          ack_err_n = 1'b1;
        if (state == RDATA)
          shreg_n = {shreg[6:0], sda_in};
      end
      if (phase == 2'd3) begin
        bitcnt_n = bitcnt + 3'd1;
        shreg_n  = {shreg[6:0], 1'b0};
        case (state)
          START: begin
            state_n  = ADDR;
            shreg_n  = {sa_q, rw_q};
            bitcnt_n = 3'd0;
          end
          ADDR:      if (bitcnt == 3'd7) state_n = ADDR_ACK;
          ADDR_ACK: begin
            if (ack_err) state_n = STOP;
            else begin
              state_n  = MADDR;
              shreg_n  = ma_q;
              bitcnt_n = 3'd0;
            end
          end
          MADDR:     if (bitcnt == 3'd7) state_n = MADDR_ACK;
          MADDR_ACK: begin
            bitcnt_n = 3'd0;
            if (ack_err) state_n = STOP;
            else if (rw_q) state_n = RDATA;
            else begin
              state_n = WDATA;
              shreg_n = wd_q;
            end
          end
          WDATA:     if (bitcnt == 3'd7) state_n = WDATA_ACK;
          WDATA_ACK: state_n = STOP;
          RDATA: begin
            // keep received bits; the byte is complete after bit 7's sample
            shreg_n = shreg;
            if (bitcnt == 3'd7) begin
              state_n = RNACK;
              rdata_n = shreg;
            end
          end
          RNACK:     state_n = STOP;
          STOP: begin
            state_n = IDLE;
            done    = 1'b1;
          end
          default:   state_n = IDLE;
        endcase
      end
    end
    {scl_n, sda_low_n} = pins(state_n, phase_n, shreg_n[7]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      phase   <= 2'd0;
      qcnt    <= '0;
      bitcnt  <= 3'd0;
      shreg   <= 8'h00;
      ack_err <= 1'b0;
      rdata   <= 8'h00;
      scl     <= 1'b1;
      sda_low <= 1'b0;
      rw_q    <= 1'b0;
      sa_q    <= 7'h00;
      ma_q    <= 8'h00;
      wd_q    <= 8'h00;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      qcnt    <= (!busy || tick) ? '0 : qcnt + 1'b1;
      bitcnt  <= bitcnt_n;
      shreg   <= shreg_n;
      ack_err <= ack_err_n;
      rdata   <= rdata_n;
      scl     <= scl_n;
      sda_low <= sda_low_n;
      if (!busy && start) begin
        rw_q <= rw;
        sa_q <= slave_addr;
        ma_q <= mem_addr;
        wd_q <= wdata;
      end
    end
  end

endmodule
